// File: rtl/core_feed_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// core_feed_sequencer_pkg
// Shared definitions for the core feed sequencer:
//   - feed_state_t : sequencer state encoding (IDLE, ISSUE, DRAIN, DONE)
//   - ACT_W_DEF / WGT_W_DEF : word widths derived from BITS_ACT, BITS_WEIGHT, PE_ROW
//   - RD_LAT       : activation/weight buffer read latency in cycles
//   - sat_inc32    : saturating 32-bit increment used by the performance counters
// ---------------------------------------------------------------------------
package core_feed_sequencer_pkg;

  localparam int BITS_ACT    = 4;
  localparam int BITS_WEIGHT = 4;
  localparam int PE_ROW      = 4;

  localparam int ACT_W_DEF = BITS_ACT * PE_ROW * 4;
  localparam int WGT_W_DEF = BITS_WEIGHT * PE_ROW * 4;

  // Cycles from buffer read enable to read data valid.
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/core_feed_sequencer_feed_addr_gen.sv
// ---------------------------------------------------------------------------
// feed_addr_gen
// Pixel (p) and accumulation (k) counters for one layer, buffer read address
// generation and first/last beat tags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : accepted layer start; captures cfg_* and clears p/k
//   advance         : a read is being issued this cycle; step the counters
//   cfg_accum_len   : accumulation steps per pixel group (>=1)
//   cfg_num_pix     : number of pixel groups (>=1)
//   cfg_act_base    : activation buffer base address
//   cfg_wgt_base    : weight buffer base address
//   act_addr        : cfg_act_base + p*accum_len + k (mod 2^ADDR_W)
//   wgt_addr        : cfg_wgt_base + k (mod 2^ADDR_W)
//   tag_first       : k == 0
//   tag_last        : k == accum_len-1
//   last_issue      : current (p,k) is the final read of the layer
// ---------------------------------------------------------------------------
module feed_addr_gen
  import core_feed_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [CNT_W-1:0]  cfg_accum_len,
  input  logic [CNT_W-1:0]  cfg_num_pix,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              tag_first,
  output logic              tag_last,
  output logic              last_issue
);

  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  npix_r;
  logic [ADDR_W-1:0] wgt_base_r;
  // Running act_base + p*accum_len, so no multiplier is needed.
  logic [ADDR_W-1:0] pix_base_r;
  logic [CNT_W-1:0]  k_r;
  logic [CNT_W-1:0]  p_r;

  logic k_end_s;
  logic p_end_s;

  // End-of-group and end-of-layer detection.
  always_comb begin
    k_end_s = (k_r == (len_r - CNT_W'(1)));
    p_end_s = (p_r == (npix_r - CNT_W'(1)));
  end

  // Layer configuration capture and p/k stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r      <= {CNT_W{1'b0}};
      npix_r     <= {CNT_W{1'b0}};
      wgt_base_r <= {ADDR_W{1'b0}};
      pix_base_r <= {ADDR_W{1'b0}};
      k_r        <= {CNT_W{1'b0}};
      p_r        <= {CNT_W{1'b0}};
    end else if (load) begin
      len_r      <= cfg_accum_len;
      npix_r     <= cfg_num_pix;
      wgt_base_r <= cfg_wgt_base;
      pix_base_r <= cfg_act_base;
      k_r        <= {CNT_W{1'b0}};
      p_r        <= {CNT_W{1'b0}};
    end else if (advance) begin
      if (k_end_s) begin
        k_r        <= {CNT_W{1'b0}};
        p_r        <= p_r + CNT_W'(1);
        pix_base_r <= pix_base_r + ADDR_W'(len_r);
      end else begin
        k_r <= k_r + CNT_W'(1);
      end
    end
  end

  // Addresses wrap silently at 2^ADDR_W.
  always_comb begin
    act_addr   = pix_base_r + ADDR_W'(k_r);
    wgt_addr   = wgt_base_r + ADDR_W'(k_r);
    tag_first  = (k_r == {CNT_W{1'b0}});
    tag_last   = k_end_s;
    last_issue = k_end_s & p_end_s;
  end

endmodule

// File: rtl/core_feed_sequencer.sv
// ---------------------------------------------------------------------------
// core_feed_sequencer
// Upstream stage of the BitBlade core: walks one layer's pixel groups and
// accumulation steps, reads the activation and weight buffers and presents
// the words to the core with bias-select / flush markers.
// Ports:
//   CLK, RST                   : clock, synchronous active-high reset
//   start                      : layer start pulse, accepted only in IDLE
//   cfg_accum_len, cfg_num_pix : layer geometry (both >=1)
//   cfg_act_base, cfg_wgt_base : buffer base addresses
//   cfg_i_prec, cfg_w_prec     : layer precisions, latched at start
//   stall                      : back-pressure; blocks new reads only
//   act_rd_en/addr/data        : activation buffer read port (1-cycle latency)
//   wgt_rd_en/addr/data        : weight buffer read port (1-cycle latency)
//   i_Act, i_Weight            : words to the core (hold when core_vld=0)
//   i_Precision, w_Precision   : latched precisions
//   core_vld                   : i_Act/i_Weight valid
//   i_Sel_Bias, i_Flush        : first / last beat of a pixel group
//   busy                       : not IDLE
//   feed_done                  : one-cycle end-of-layer pulse
// Optional build macro FEEDER_PERF_CNT_EN adds:
//   perf_busy_cyc, perf_stall_cyc : saturating 32-bit cycle counters
// ---------------------------------------------------------------------------
module core_feed_sequencer
  import core_feed_sequencer_pkg::*;
#(
  parameter int ACT_W  = ACT_W_DEF,
  parameter int WGT_W  = WGT_W_DEF,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_accum_len,
  input  logic [CNT_W-1:0]  cfg_num_pix,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic [1:0]        cfg_i_prec,
  input  logic [1:0]        cfg_w_prec,
  input  logic              stall,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [ACT_W-1:0]  act_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [WGT_W-1:0]  wgt_rd_data,
  output logic [ACT_W-1:0]  i_Act,
  output logic [WGT_W-1:0]  i_Weight,
  output logic [1:0]        i_Precision,
  output logic [1:0]        w_Precision,
  output logic              core_vld,
  output logic              i_Sel_Bias,
  output logic              i_Flush,
  output logic              busy,
  output logic              feed_done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  feed_state_t state_r;
  feed_state_t next_state_s;

  logic accept_s;
  logic issue_s;
  logic drain_done_s;

  logic [ADDR_W-1:0] gen_act_addr_s;
  logic [ADDR_W-1:0] gen_wgt_addr_s;
  logic              gen_first_s;
  logic              gen_last_s;
  logic              gen_last_issue_s;

  // Tag/valid pipeline aligned with the buffer read latency.
  logic [RD_LAT-1:0] vld_pipe_r;
  logic [RD_LAT-1:0] first_pipe_r;
  logic [RD_LAT-1:0] last_pipe_r;

  feed_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk           (CLK),
    .rst           (RST),
    .load          (accept_s),
    .advance       (issue_s),
    .cfg_accum_len (cfg_accum_len),
    .cfg_num_pix   (cfg_num_pix),
    .cfg_act_base  (cfg_act_base),
    .cfg_wgt_base  (cfg_wgt_base),
    .act_addr      (gen_act_addr_s),
    .wgt_addr      (gen_wgt_addr_s),
    .tag_first     (gen_first_s),
    .tag_last      (gen_last_s),
    .last_issue    (gen_last_issue_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, read issue and drain completion.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          issue_s = 1'b1;
          if (gen_last_issue_s) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = ISSUE;
          end
        end else begin
          next_state_s = ISSUE;
        end
      end
      DRAIN: begin
        // No reads are issued here, so the final beat is the one on the
        // output while nothing remains behind it in the tag pipeline.
        if (core_vld && (vld_pipe_r == {RD_LAT{1'b0}})) begin
          drain_done_s = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Read ports; addresses are forced to zero when no read is issued.
  always_comb begin
    act_rd_en = issue_s;
    wgt_rd_en = issue_s;
    if (issue_s) begin
      act_rd_addr = gen_act_addr_s;
      wgt_rd_addr = gen_wgt_addr_s;
    end else begin
      act_rd_addr = {ADDR_W{1'b0}};
      wgt_rd_addr = {ADDR_W{1'b0}};
    end
  end

  // Tag pipeline: reset discards every in-flight beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe_r   <= {RD_LAT{1'b0}};
      first_pipe_r <= {RD_LAT{1'b0}};
      last_pipe_r  <= {RD_LAT{1'b0}};
    end else begin
      vld_pipe_r[0]   <= issue_s;
      first_pipe_r[0] <= gen_first_s;
      last_pipe_r[0]  <= gen_last_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i]   <= vld_pipe_r[i-1];
        first_pipe_r[i] <= first_pipe_r[i-1];
        last_pipe_r[i]  <= last_pipe_r[i-1];
      end
    end
  end

  // Core-facing output registers; data words hold between beats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_Act      <= {ACT_W{1'b0}};
      i_Weight   <= {WGT_W{1'b0}};
      core_vld   <= 1'b0;
      i_Sel_Bias <= 1'b0;
      i_Flush    <= 1'b0;
    end else begin
      core_vld   <= vld_pipe_r[RD_LAT-1];
      i_Sel_Bias <= vld_pipe_r[RD_LAT-1] & first_pipe_r[RD_LAT-1];
      i_Flush    <= vld_pipe_r[RD_LAT-1] & last_pipe_r[RD_LAT-1];
      if (vld_pipe_r[RD_LAT-1]) begin
        i_Act    <= act_rd_data;
        i_Weight <= wgt_rd_data;
      end
    end
  end

  // Precision latch, busy and done flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_Precision <= 2'b00;
      w_Precision <= 2'b00;
      busy        <= 1'b0;
      feed_done   <= 1'b0;
    end else begin
      if (accept_s) begin
        i_Precision <= cfg_i_prec;
        w_Precision <= cfg_w_prec;
      end
      busy      <= (next_state_s != IDLE);
      feed_done <= drain_done_s;
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  // Saturating busy / stall cycle counters, cleared on each accepted start.
  always_ff @(posedge CLK) begin
    if (RST || accept_s) begin
      perf_busy_cyc  <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else begin
      if (busy) begin
        perf_busy_cyc <= sat_inc32(perf_busy_cyc);
      end
      if ((state_r == ISSUE) && stall) begin
        perf_stall_cyc <= sat_inc32(perf_stall_cyc);
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
